// File: rtl/bram_rd_pkg.sv
// Shared FSM state type and default BRAM geometry for the block reader
// and the BRAM it drains.
package bram_rd_pkg;

  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 64;
  localparam int BRAM_DEPTH  = 1058;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/bram_block_reader_if.sv
// Control, BRAM read port and output stream bundle of bram_block_reader.
// The checksum signal exists only when BRAM_RD_CHECKSUM_EN is defined.
interface bram_block_reader_if #(
  parameter int ADDR_W = bram_rd_pkg::BRAM_ADDR_W,
  parameter int DATA_W = bram_rd_pkg::BRAM_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dataout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef BRAM_RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, base_addr, word_count, bram_dataout, m_ready,
    output busy, done, bram_addr, m_data, m_valid, m_last, checksum
  );

  modport slave (
    output start, base_addr, word_count, bram_dataout, m_ready,
    input  busy, done, bram_addr, m_data, m_valid, m_last, checksum
  );
`else
  modport master (
    input  start, base_addr, word_count, bram_dataout, m_ready,
    output busy, done, bram_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, base_addr, word_count, bram_dataout, m_ready,
    input  busy, done, bram_addr, m_data, m_valid, m_last
  );
`endif

endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry FIFO between BRAM read data and the output stream; the head
// entry stays put while the sink stalls.
module bram_rd_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_wr_ptr) r_mem1 <= i_data;
        else          r_mem0 <= i_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_data = r_rd_ptr ? r_mem1 : r_mem0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/bram_block_reader.sv
// Reads a block of sequential BRAM words and streams them out through a skid FIFO.
// Define BRAM_RD_CHECKSUM_EN to add a per-block XOR checksum of streamed words.
module bram_block_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DEPTH  = BRAM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  bram_block_reader_if.master bus
);

  rd_state_t         r_state;
  rd_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_issued;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_pop;
  logic              w_busy;
  logic              w_done;
  logic [1:0]        w_occ;
  logic [2:0]        w_level;
  logic [DATA_W:0]   w_fifo_q;
  logic              w_fifo_valid;

  assign w_start_ok   = (r_state == IDLE) && bus.start;
  assign w_pop        = w_fifo_valid && bus.m_ready;
  // Words held plus words on their way, after this cycle's pop; keep it below 2.
  assign w_level      = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue      = (r_state == READ) && (r_issued != r_count) && (w_level < 3'd2);
  assign w_last_issue = (r_issued == r_count - ADDR_W'(1));
  assign w_addr_nxt   = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A zero-length block still passes one busy cycle through READ before DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = READ;
      READ:    if (r_issued == r_count) w_next = (r_count == '0) ? DONE : DRAIN;
      DRAIN:   if (w_pop && w_fifo_q[DATA_W]) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      READ, DRAIN: w_busy = 1'b1;
      DONE:        w_done = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr          <= '0;
      r_count         <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_issue;
      if (w_start_ok) begin
        r_addr   <= bus.base_addr;
        r_count  <= bus.word_count;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= w_addr_nxt;
        r_issued <= r_issued + ADDR_W'(1);
      end
    end
  end

  bram_rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, bus.bram_dataout}),
    .o_data  (w_fifo_q),
    .o_valid (w_fifo_valid),
    .i_ready (bus.m_ready),
    .o_occ   (w_occ)
  );

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.bram_addr = r_addr;
  assign bus.m_data    = w_fifo_q[DATA_W-1:0];
  assign bus.m_valid   = w_fifo_valid;
  assign bus.m_last    = w_fifo_valid && w_fifo_q[DATA_W];

`ifdef BRAM_RD_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (w_pop)      r_checksum <= r_checksum ^ w_fifo_q[DATA_W-1:0];
  end

  assign bus.checksum = r_checksum;
`endif

endmodule

// File: tb/tb_bram_block_reader.sv
// Self-checking bench for bram_block_reader: table vectors, random blocks against
// a queue-based stream model, plus reset-abort and start-ignore sequences.
module tb_bram_block_reader;
  import bram_rd_pkg::*;

  localparam int DEPTH = BRAM_DEPTH;

  typedef struct {
    int          base;
    int          count;
    int          pct;
    logic [63:0] first;
    logic [63:0] last;
    bit          spur;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [63:0] bram_mem [0:DEPTH-1];

  bram_block_reader_if bus ();

  bram_block_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered BRAM port; out-of-range addresses return a recognisable poison word.
  always @(posedge clk) begin
    if (int'(bus.bram_addr) < DEPTH) bus.bram_dataout <= bram_mem[int'(bus.bram_addr)];
    else bus.bram_dataout <= 64'hDEAD_0000_0000_0000 | 64'(bus.bram_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one block; returns at the negedge where done is seen (or on timeout).
  task automatic run_block(input int base, input int count, input int ready_pct,
                           input logic [63:0] exp_first, input logic [63:0] exp_last,
                           input bit check_ends, input bit spurious);
    logic [63:0] exp_q[$];
    logic [63:0] xsum;
    logic [63:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    bit          got_done;
    bit          rdy;
    int          k;
    int          beats;
    int          first_k;
    int          hs_k;
    int          limit;
    for (int i = 0; i < count; i++) exp_q.push_back(bram_mem[(base + i) % DEPTH]);
    xsum = '0; prev_data = '0; prev_last = 1'b0; prev_stall = 1'b0; got_done = 1'b0;
    beats = 0; first_k = -1; hs_k = -1; limit = count * 20 + 50;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 11'(base);
    bus.word_count = 11'(count);
    bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("addr_after_start", 64'(bus.bram_addr), 64'(base));
`ifdef BRAM_RD_CHECKSUM_EN
    chk("checksum_cleared", bus.checksum, 64'd0);
`endif
    while (!got_done && k < limit) begin
      bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("beat_count", 64'(beats), 64'(count));
        if (count == 0) chk("done_k_zero", 64'(k), 64'd2);
        else chk("done_after_last", 64'(k), 64'(hs_k + 1));
        if (count > 0 && ready_pct >= 100) chk("done_k_full_rate", 64'(k), 64'(count + 3));
`ifdef BRAM_RD_CHECKSUM_EN
        chk("checksum_at_done", bus.checksum, xsum);
`endif
      end else begin
        chk("busy_held", 64'(bus.busy), 64'd1);
        if (prev_stall) begin
          chk("hold_valid", 64'(bus.m_valid), 64'd1);
          chk("hold_data", bus.m_data, prev_data);
          chk("hold_last", 64'(bus.m_last), 64'(prev_last));
        end
        if (bus.m_valid && first_k < 0) first_k = k;
        rdy = ($urandom_range(0, 99) < ready_pct);
        if (spurious && k == 2) begin
          bus.start = 1'b1;
          bus.base_addr = 11'd0;
          bus.word_count = 11'd5;
        end
        bus.m_ready = rdy;
        if (bus.m_valid && rdy) begin
          if (beats < count) begin
            chk("beat_data", bus.m_data, exp_q[beats]);
            chk("beat_last", 64'(bus.m_last), 64'(beats == count - 1));
            if (check_ends && beats == 0) chk("first_word", bus.m_data, exp_first);
            if (check_ends && beats == count - 1) chk("last_word", bus.m_data, exp_last);
          end else begin
            chk("extra_beat", 64'(beats + 1), 64'(count));
          end
          xsum = xsum ^ bus.m_data;
          hs_k = k;
          beats++;
        end
        prev_stall = bus.m_valid && !rdy;
        prev_data = bus.m_data;
        prev_last = bus.m_last;
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    bus.m_ready = 1'b0;
    if (!got_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles, required within %0d", k, limit);
    end
    if (count > 0) chk("first_valid_k", 64'(first_k), 64'd3);
    else chk("no_valid_zero", 64'(first_k), 64'(-1));
  endtask

  vec_t vecs [8];
  int   beats;

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int a = 0; a < DEPTH; a++) bram_mem[a] = 64'h0F9C + 64'(a);
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.m_ready = 1'b0;
    reset = 1'b1;

    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_addr", 64'(bus.bram_addr), 64'd0);
    chk("rst_data", bus.m_data, 64'd0);
    chk("rst_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_last", 64'(bus.m_last), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{100,  64,   100, 64'h1000, 64'h103F, 1'b0};
    vecs[1] = '{100,  64,   50,  64'h1000, 64'h103F, 1'b0};
    vecs[2] = '{1056, 4,    100, 64'h13BC, 64'h0F9D, 1'b0};
    vecs[3] = '{0,    0,    100, 64'h0,    64'h0,    1'b0};
    vecs[4] = '{1050, 20,   70,  64'h13B6, 64'h0FA7, 1'b0};
    vecs[5] = '{5,    1,    100, 64'h0FA1, 64'h0FA1, 1'b0};
    vecs[6] = '{1057, 1100, 80,  64'h13BD, 64'h0FC4, 1'b0};
    vecs[7] = '{100,  10,   100, 64'h1000, 64'h1009, 1'b1};
    for (int v = 0; v < 8; v++)
      run_block(vecs[v].base, vecs[v].count, vecs[v].pct, vecs[v].first, vecs[v].last,
                vecs[v].count > 0, vecs[v].spur);

    // start raised in the done cycle must be ignored
    bus.start = 1'b1;
    bus.base_addr = 11'd200;
    bus.word_count = 11'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done_ignored", 64'(bus.busy), 64'd0);

    // reset in the middle of a 64-word block
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 11'd100;
    bus.word_count = 11'd64;
    @(negedge clk);
    bus.start = 1'b0;
    bus.m_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 200 && beats < 20; c++) begin
      if (bus.m_valid) beats++;
      @(negedge clk);
    end
    chk("abort_beats", 64'(beats), 64'd20);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_addr", 64'(bus.bram_addr), 64'd0);
    chk("abort_data", bus.m_data, 64'd0);
    chk("abort_valid", 64'(bus.m_valid), 64'd0);
    chk("abort_last", 64'(bus.m_last), 64'd0);
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", 64'(bus.done), 64'd0);
      chk("idle_after_abort", 64'(bus.busy), 64'd0);
    end
    run_block(0, 2, 100, 64'h0F9C, 64'h0F9D, 1'b1, 1'b0);

    // checksum block 1^2^4, then a second block that must restart from zero
    bram_mem[500] = 64'h1;
    bram_mem[501] = 64'h2;
    bram_mem[502] = 64'h4;
    run_block(500, 3, 100, 64'h1, 64'h4, 1'b1, 1'b0);
`ifdef BRAM_RD_CHECKSUM_EN
    chk("checksum_7", bus.checksum, 64'h7);
`endif
    run_block(100, 3, 60, 64'h1000, 64'h1002, 1'b1, 1'b0);
`ifdef BRAM_RD_CHECKSUM_EN
    chk("checksum_second", bus.checksum, 64'h1003);
`endif

    for (int r = 0; r < 8; r++)
      run_block(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(25, 100)), 64'h0, 64'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
